// File: rtl/sha256_mem_responder.sv
`default_nettype none
// ============================================================================
// Module  : sha256_mem_responder
// Brief   : Word memory serving the SHA-256 core, with host load/unload and digest capture.
// Revision: 1.0  initial release
// ============================================================================
module sha256_mem_responder #(
    parameter int DEPTH        = 256,
    parameter int DIGEST_WORDS = 8
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        core_active,
    input  logic                        mem_we,
    input  logic [15:0]                 mem_addr,
    input  logic [31:0]                 mem_write_data,
    output logic [31:0]                 mem_read_data,
    input  logic                        host_valid,
    output logic                        host_ready,
    input  logic                        host_we,
    input  logic [15:0]                 host_addr,
    input  logic [31:0]                 host_wdata,
    output logic                        host_rvalid,
    output logic [31:0]                 host_rdata,
    input  logic [15:0]                 digest_base,
    input  logic                        arm,
    output logic                        digest_valid,
    output logic [32*DIGEST_WORDS-1:0]  digest,
    input  logic                        err_clr,
    output logic                        err_oob
);

    localparam int          AW          = $clog2(DEPTH);
    localparam int          SW          = $clog2(DIGEST_WORDS);
    localparam logic [16:0] C_DEPTH_EXT = 17'(DEPTH);
    localparam logic [16:0] C_WIN_EXT   = 17'(DIGEST_WORDS);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARMED   = 2'd1,
        S_CAPTURE = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    logic [31:0]                    r_mem [DEPTH];
    logic [31:0]                    r_mem_read_data;
    logic                           r_host_rvalid;
    logic [31:0]                    r_host_rdata;
    logic                           r_err_oob;
    logic [15:0]                    r_base;
    logic [DIGEST_WORDS-1:0]        r_mask;
    logic [DIGEST_WORDS-1:0][31:0]  r_dig;
    state_t                         r_state;
    state_t                         w_state_next;

    logic                    w_core_inr;
    logic                    w_host_inr;
    logic                    w_host_acc;
    logic                    w_core_wr;
    logic                    w_host_wr;
    logic                    w_oob;
    logic [16:0]             w_win_end;
    logic                    w_hit;
    logic                    w_cap;
    logic [SW-1:0]           w_slot;
    logic [SW-1:0]           w_didx;
    logic [DIGEST_WORDS-1:0] w_mask_next;

    assign w_core_inr = {1'b0, mem_addr} < C_DEPTH_EXT;
    assign w_host_inr = {1'b0, host_addr} < C_DEPTH_EXT;
    assign host_ready = !core_active && !r_host_rvalid;
    assign w_host_acc = host_valid && host_ready;
    assign w_core_wr  = core_active && mem_we && w_core_inr;
    assign w_host_wr  = w_host_acc && host_we && w_host_inr;
    // Every active core cycle is a read access, so an OOB address flags even without a write.
    assign w_oob      = (core_active && !w_core_inr) || (w_host_acc && !w_host_inr);

    assign w_win_end  = {1'b0, r_base} + C_WIN_EXT;
    assign w_hit      = core_active && mem_we &&
                        ({1'b0, mem_addr} >= {1'b0, r_base}) &&
                        ({1'b0, mem_addr} <  w_win_end);
    assign w_cap      = w_hit && !arm && ((r_state == S_ARMED) || (r_state == S_CAPTURE));
    // Offset within a power-of-two window only needs the low bits of the difference.
    assign w_slot     = mem_addr[SW-1:0] - r_base[SW-1:0];
    assign w_didx     = SW'(DIGEST_WORDS - 1) - w_slot;
    assign w_mask_next = r_mask | (w_cap ? (DIGEST_WORDS'(1) << w_slot) : '0);

    // Memory array is deliberately not reset so contents survive a reset.
    always_ff @(posedge clk) begin
        if (w_core_wr) begin
            r_mem[mem_addr[AW-1:0]] <= mem_write_data;
        end else if (w_host_wr) begin
            r_mem[host_addr[AW-1:0]] <= host_wdata;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mem_read_data <= '0;
            r_host_rvalid   <= 1'b0;
            r_host_rdata    <= '0;
            r_err_oob       <= 1'b0;
        end else begin
            if (core_active) begin
                r_mem_read_data <= w_core_inr ? r_mem[mem_addr[AW-1:0]] : '0;
            end
            r_host_rvalid <= w_host_acc && !host_we;
            if (w_host_acc && !host_we) begin
                r_host_rdata <= w_host_inr ? r_mem[host_addr[AW-1:0]] : '0;
            end
            if (w_oob) begin
                r_err_oob <= 1'b1;
            end else if (err_clr) begin
                r_err_oob <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (arm) begin
            w_state_next = S_ARMED;
        end else if (w_cap) begin
            w_state_next = (&w_mask_next) ? S_DONE : S_CAPTURE;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_base <= '0;
            r_mask <= '0;
            r_dig  <= '0;
        end else if (arm) begin
            r_base <= digest_base;
            r_mask <= '0;
            r_dig  <= '0;
        end else if (w_cap) begin
            r_mask        <= w_mask_next;
            r_dig[w_didx] <= mem_write_data;
        end
    end

    assign mem_read_data = r_mem_read_data;
    assign host_rvalid   = r_host_rvalid;
    assign host_rdata    = r_host_rdata;
    assign err_oob       = r_err_oob;
    assign digest_valid  = (r_state == S_DONE);
    assign digest        = r_dig;

endmodule
`default_nettype wire
